ram_rd_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the read port of `ram_1r1w_sync`. It lets the instruction-fetch requester (port 0) and the load/store requester (port 1) share one synchronous-read RAM. Each requester gets a valid/ready request channel and a valid/ready response channel. The write port passes through from requester 1, and same-cycle write-to-read forwarding gives read-after-write ordering.

---
 rtl/ram_rd_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// ram_rd_arbiter
//
// Round-robin arbiter and sequencer for the read port of a synchronous-read
// RAM (ram_1r1w_sync) shared by two requesters: instruction fetch (port 0)
// and load/store (port 1). At most one read is in flight at a time. Its
// response is held on the owner's response channel until that requester
// consumes it. The write port is a zero-latency pass-through from
// requester 1. A write that hits the address being read in the same cycle
// is forwarded into the response, so that read observes the write.
//
// Parameters:
//   width_p  data width (must match the RAM)
//   depth_p  RAM depth; address width aw = $clog2(depth_p)
//
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   reqN_valid_i/addr_i/ready_o    read request channel of requester N
//   rspN_valid_o/data_o/ready_i    read response channel of requester N
//   wr_valid_i/addr_i/data_i       write strobe from requester 1 (no ready)
//   ram_rd_valid_o/addr_o          read strobe and address to the RAM
//   ram_rd_data_i                  registered read data from the RAM
//   ram_wr_valid_o/addr_o/data_o   write pass-through to the RAM
// -----------------------------------------------------------------------------
module ram_rd_arbiter #(
   parameter  int width_p = 32,
   parameter  int depth_p = 512,
   localparam int aw      = $clog2(depth_p)
) (
   input  logic               clk_i,
   input  logic               reset_i,

   input  logic               req0_valid_i,
   input  logic [aw-1:0]      req0_addr_i,
   output logic               req0_ready_o,
   output logic               rsp0_valid_o,
   output logic [width_p-1:0] rsp0_data_o,
   input  logic               rsp0_ready_i,

   input  logic               req1_valid_i,
   input  logic [aw-1:0]      req1_addr_i,
   output logic               req1_ready_o,
   output logic               rsp1_valid_o,
   output logic [width_p-1:0] rsp1_data_o,
   input  logic               rsp1_ready_i,

   input  logic               wr_valid_i,
   input  logic [aw-1:0]      wr_addr_i,
   input  logic [width_p-1:0] wr_data_i,

   output logic               ram_rd_valid_o,
   output logic [aw-1:0]      ram_rd_addr_o,
   input  logic [width_p-1:0] ram_rd_data_i,

   output logic               ram_wr_valid_o,
   output logic [aw-1:0]      ram_wr_addr_o,
   output logic [width_p-1:0] ram_wr_data_o
);

   // State
   logic               r_pend;      // a response is outstanding
   logic               r_pend_id;   // owner of the outstanding response
   logic               r_last;      // requester granted most recently
   logic               r_fwd;       // response data comes from r_fwd_data
   logic [width_p-1:0] r_fwd_data;  // write data captured on an address hit

   // Per-requester views, packed so both ports share one description
   logic [1:0]          w_req_valid;
   logic [1:0]          w_rsp_ready;
   logic [1:0]          w_req_ready;
   logic [1:0]          w_rsp_valid;
   logic [aw-1:0]       w_req_addr [2];

   logic                w_owner_fire;
   logic                w_free;
   logic                w_grant;
   logic                w_accept;
   logic [aw-1:0]       w_rd_addr;
   logic                w_fwd_hit;
   logic [width_p-1:0]  w_rsp_data;

   assign w_req_valid   = {req1_valid_i, req0_valid_i};
   assign w_rsp_ready   = {rsp1_ready_i, rsp0_ready_i};
   assign w_req_addr[0] = req0_addr_i;
   assign w_req_addr[1] = req1_addr_i;

   // The slot frees up in the same cycle the owner takes its response, so a
   // new read can be issued back-to-back. This makes rsp*_ready_i a
   // combinational input to req*_ready_o on purpose.
   assign w_owner_fire = r_pend && w_rsp_ready[r_pend_id];
   assign w_free       = !r_pend || w_owner_fire;

   // Lone requester wins outright; on a tie the one not served last wins.
   always_comb begin
      if (w_req_valid == 2'b11) begin
         w_grant = ~r_last;
      end else begin
         w_grant = w_req_valid[1];
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         // Ready is forced low while reset is asserted so that nothing is
         // accepted before the state registers are usable.
         assign w_req_ready[gi] = !reset_i && w_free && w_req_valid[gi] &&
                                  (w_grant == 1'(gi));
         assign w_rsp_valid[gi] = r_pend && (r_pend_id == 1'(gi));
      end
   endgenerate

   assign w_accept  = |w_req_ready;
   assign w_rd_addr = w_req_addr[w_grant];

   // The RAM returns old data when a read and a write to the same address
   // share a cycle; capturing the write data here gives read-after-write.
   assign w_fwd_hit = wr_valid_i && (wr_addr_i == w_rd_addr);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_pend     <= 1'b0;
         r_pend_id  <= 1'b0;
         r_last     <= 1'b1;   // requester 0 wins the first tie
         r_fwd      <= 1'b0;
         r_fwd_data <= '0;
      end else if (w_accept) begin
         // Also covers "consume and accept" in one cycle: the slot reloads.
         r_pend    <= 1'b1;
         r_pend_id <= w_grant;
         r_last    <= w_grant;
         r_fwd     <= w_fwd_hit;
         if (w_fwd_hit) begin
            r_fwd_data <= wr_data_i;
         end
      end else if (w_owner_fire) begin
         r_pend <= 1'b0;
      end
   end

   // Later writes cannot disturb a stalled response: the RAM only reloads its
   // read register on a read strobe, and r_fwd_data only loads on accept.
   assign w_rsp_data = r_fwd ? r_fwd_data : ram_rd_data_i;

   assign req0_ready_o = w_req_ready[0];
   assign req1_ready_o = w_req_ready[1];
   assign rsp0_valid_o = w_rsp_valid[0];
   assign rsp1_valid_o = w_rsp_valid[1];
   assign rsp0_data_o  = w_rsp_data;
   assign rsp1_data_o  = w_rsp_data;

   // Strobe only on accept so the RAM holds its output during a stall.
   assign ram_rd_valid_o = w_accept;
   assign ram_rd_addr_o  = w_rd_addr;

   assign ram_wr_valid_o = wr_valid_i;
   assign ram_wr_addr_o  = wr_addr_i;
   assign ram_wr_data_o  = wr_data_i;

endmodule
